memory_board_ctrl: RTL and testbench

Parametrised two-player memory-game board controller for the FPGA game top level. It owns the cursor, the per-card visibility and ownership state, the two-card flip/compare sequence, the mismatch reveal hold, turn passing, scores and end-of-game detection. Debounced, single-cycle button pulses come in; the display/VGA layer and the 7-segment layer consume the outputs.

---
 rtl/memory_pkg.sv | 42 ++++
 rtl/memory_board_ctrl_if.sv | 41 ++++
 rtl/memory_hold_timer.sv | 67 ++++++
 rtl/memory_board_ctrl.sv | 238 +++++++++++++++++++++++
 tb/tb_memory_board_ctrl.sv | 391 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/memory_pkg.sv
// -----------------------------------------------------------------------------
// memory_pkg
// Shared types and constants for the memory-game board controller.
//   card_state_t : per-card visibility/ownership encoding (matches card_state bus)
//   board_fsm_t  : flip/compare sequencer states
//   WIN_*        : winner output encoding
//   owner_state  : card state that marks a card as won by a given player
// -----------------------------------------------------------------------------
package memory_pkg;

  typedef enum logic [1:0] {
    HIDDEN = 2'b00,
    SHOWN  = 2'b01,
    OWN_P1 = 2'b10,
    OWN_P2 = 2'b11
  } card_state_t;

  typedef enum logic [2:0] {
    FIRST   = 3'd0,
    SECOND  = 3'd1,
    COMPARE = 3'd2,
    HOLD    = 3'd3,
    FINISH  = 3'd4
  } board_fsm_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_TIE  = 2'b11;

  // Player 0 is P1, player 1 is P2.
  function automatic card_state_t owner_state(input logic plr);
    card_state_t st;
    if (plr) begin
      st = OWN_P2;
    end else begin
      st = OWN_P1;
    end
    return st;
  endfunction

endpackage

// File: rtl/memory_board_ctrl_if.sv
// -----------------------------------------------------------------------------
// memory_board_ctrl_if
// Bundles the button pulses, the card label table and all board outputs.
//   master : the game top level / bench (drives pulses and labels)
//   slave  : memory_board_ctrl (drives cursor, card_state, scores, status)
// -----------------------------------------------------------------------------
interface memory_board_ctrl_if #(
  parameter int N_CARDS = 16,
  parameter int LABEL_W = 4,
  parameter int SCORE_W = 6
);

  localparam int CUR_W = $clog2(N_CARDS);

  logic                         move_next;
  logic                         move_prev;
  logic                         select;
  logic [N_CARDS*LABEL_W-1:0]   labels;
  logic [CUR_W-1:0]             cursor;
  logic [2*N_CARDS-1:0]         card_state;
  logic [LABEL_W-1:0]           cur_label;
  logic                         player;
  logic [SCORE_W-1:0]           score_p1;
  logic [SCORE_W-1:0]           score_p2;
  logic                         hold_active;
  logic                         game_over;
  logic [1:0]                   winner;

  modport master (
    output move_next, move_prev, select, labels,
    input  cursor, card_state, cur_label, player, score_p1, score_p2,
           hold_active, game_over, winner
  );

  modport slave (
    input  move_next, move_prev, select, labels,
    output cursor, card_state, cur_label, player, score_p1, score_p2,
           hold_active, game_over, winner
  );

endinterface

// File: rtl/memory_hold_timer.sv
// -----------------------------------------------------------------------------
// memory_hold_timer
// Counts out the mismatch reveal period.
//   clk, rst : clock, asynchronous active-low reset
//   start    : load the counter (one cycle)
//   busy     : high from the cycle after start until the cycle after done
//   done     : one-cycle pulse in the HOLD_CYCLES-th cycle after start, so a
//              consumer that leaves its wait state on done spends exactly
//              HOLD_CYCLES cycles there
// -----------------------------------------------------------------------------
module memory_hold_timer #(
  parameter int unsigned HOLD_CYCLES = 25000000
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy,
  output logic done
);

  localparam int CNT_W = (HOLD_CYCLES > 32'd1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Next-count logic; done is pre-computed one cycle early so it is registered.
  always_comb begin
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (start) begin
      cnt_d  = CNT_LOAD;
      busy_d = 1'b1;
      done_d = (HOLD_CYCLES == 32'd1);
    end else if (busy_q) begin
      if (cnt_q == CNT_ZERO) begin
        busy_d = 1'b0;
      end else begin
        cnt_d  = cnt_q - CNT_ONE;
        done_d = (cnt_q == CNT_ONE);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= CNT_ZERO;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: rtl/memory_board_ctrl.sv
// -----------------------------------------------------------------------------
// memory_board_ctrl
// Two-player memory-game board: cursor, per-card state, flip/compare sequence,
// mismatch reveal hold, turn passing, scores and end-of-game detection.
//   clk, rst : clock, asynchronous active-low reset
//   bus      : memory_board_ctrl_if.slave
//              in : move_next, move_prev, select (single-cycle pulses), labels
//              out: cursor, card_state, cur_label (combinational), player,
//                   score_p1, score_p2, hold_active, game_over, winner
// -----------------------------------------------------------------------------
module memory_board_ctrl
  import memory_pkg::*;
#(
  parameter int          N_CARDS     = 16,
  parameter int          LABEL_W     = 4,
  parameter int unsigned HOLD_CYCLES = 25000000,
  parameter int          SCORE_W     = 6
) (
  input  logic                clk,
  input  logic                rst,
  memory_board_ctrl_if.slave  bus
);

  localparam int                 CUR_W     = $clog2(N_CARDS);
  localparam logic [CUR_W-1:0]   CUR_LAST  = CUR_W'(N_CARDS - 1);
  localparam logic [CUR_W-1:0]   CUR_ZERO  = {CUR_W{1'b0}};
  localparam logic [CUR_W-1:0]   CUR_ONE   = CUR_W'(1'b1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};
  localparam logic [SCORE_W:0]   ALL_PAIRS = (SCORE_W + 1)'(N_CARDS / 2);

  board_fsm_t         state_q, state_d;
  logic [CUR_W-1:0]   cursor_q, cursor_d;
  card_state_t        cards_q [N_CARDS];
  card_state_t        cards_d [N_CARDS];
  logic [CUR_W-1:0]   idx_a_q, idx_a_d;
  logic [CUR_W-1:0]   idx_b_q, idx_b_d;
  logic               player_q, player_d;
  logic [SCORE_W-1:0] score_p1_q, score_p1_d;
  logic [SCORE_W-1:0] score_p2_q, score_p2_d;
  logic               hold_active_q, hold_active_d;
  logic               game_over_q, game_over_d;
  logic [1:0]         winner_q, winner_d;

  logic               timer_start_s;
  logic               timer_busy_s;
  logic               timer_done_s;
  logic [LABEL_W-1:0] label_a_s;
  logic [LABEL_W-1:0] label_b_s;
  logic [SCORE_W:0]   pairs_s;
  logic [LABEL_W-1:0] cur_label_s;
  logic [2*N_CARDS-1:0] card_state_s;

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
    logic [SCORE_W-1:0] r;
    if (s == SCORE_MAX) begin
      r = s;
    end else begin
      r = s + SCORE_W'(1'b1);
    end
    return r;
  endfunction

  function automatic logic [1:0] decide_winner(input logic [SCORE_W-1:0] p1,
                                               input logic [SCORE_W-1:0] p2);
    logic [1:0] w;
    if (p1 > p2) begin
      w = WIN_P1;
    end else if (p2 > p1) begin
      w = WIN_P2;
    end else begin
      w = WIN_TIE;
    end
    return w;
  endfunction

  memory_hold_timer #(
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_hold_timer (
    .clk   (clk),
    .rst   (rst),
    .start (timer_start_s),
    .busy  (timer_busy_s),
    .done  (timer_done_s)
  );

  // Next-state, cursor, card and score logic.
  always_comb begin
    state_d       = state_q;
    cursor_d      = cursor_q;
    cards_d       = cards_q;
    idx_a_d       = idx_a_q;
    idx_b_d       = idx_b_q;
    player_d      = player_q;
    score_p1_d    = score_p1_q;
    score_p2_d    = score_p2_q;
    hold_active_d = 1'b0;
    game_over_d   = game_over_q;
    winner_d      = winner_q;
    timer_start_s = 1'b0;
    pairs_s       = {(SCORE_W + 1){1'b0}};
    label_a_s     = bus.labels[idx_a_q*LABEL_W +: LABEL_W];
    label_b_s     = bus.labels[idx_b_q*LABEL_W +: LABEL_W];

    // Cursor moves in every state except FINISH; simultaneous pulses cancel.
    if (state_q == FINISH) begin
      cursor_d = cursor_q;
    end else if (bus.move_next && !bus.move_prev) begin
      cursor_d = (cursor_q == CUR_LAST) ? CUR_ZERO : cursor_q + CUR_ONE;
    end else if (bus.move_prev && !bus.move_next) begin
      cursor_d = (cursor_q == CUR_ZERO) ? CUR_LAST : cursor_q - CUR_ONE;
    end else begin
      cursor_d = cursor_q;
    end

    case (state_q)
      FIRST: begin
        if (bus.select && (cards_q[cursor_q] == HIDDEN)) begin
          cards_d[cursor_q] = SHOWN;
          idx_a_d           = cursor_q;
          state_d           = SECOND;
        end else begin
          state_d = FIRST;
        end
      end
      SECOND: begin
        // The first card is already SHOWN, so only a hidden card qualifies.
        if (bus.select && (cards_q[cursor_q] == HIDDEN)) begin
          cards_d[cursor_q] = SHOWN;
          idx_b_d           = cursor_q;
          state_d           = COMPARE;
        end else begin
          state_d = SECOND;
        end
      end
      COMPARE: begin
        if (label_a_s == label_b_s) begin
          cards_d[idx_a_q] = owner_state(player_q);
          cards_d[idx_b_q] = owner_state(player_q);
          if (player_q) begin
            score_p2_d = sat_inc(score_p2_q);
          end else begin
            score_p1_d = sat_inc(score_p1_q);
          end
          pairs_s = {1'b0, score_p1_d} + {1'b0, score_p2_d};
          if (pairs_s == ALL_PAIRS) begin
            state_d     = FINISH;
            game_over_d = 1'b1;
            winner_d    = decide_winner(score_p1_d, score_p2_d);
          end else begin
            state_d = FIRST;
          end
        end else begin
          timer_start_s = 1'b1;
          hold_active_d = 1'b1;
          state_d       = HOLD;
        end
      end
      HOLD: begin
        // An idle timer here can only mean it was disturbed; leave HOLD then too.
        if (timer_done_s || !timer_busy_s) begin
          cards_d[idx_a_q] = HIDDEN;
          cards_d[idx_b_q] = HIDDEN;
          player_d         = ~player_q;
          state_d          = FIRST;
        end else begin
          hold_active_d = 1'b1;
        end
      end
      FINISH: begin
        state_d     = FINISH;
        game_over_d = 1'b1;
      end
      default: begin
        state_d = FIRST;
      end
    endcase
  end

  // Board state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= FIRST;
      cursor_q      <= CUR_ZERO;
      for (int i = 0; i < N_CARDS; i++) begin
        cards_q[i] <= HIDDEN;
      end
      idx_a_q       <= CUR_ZERO;
      idx_b_q       <= CUR_ZERO;
      player_q      <= 1'b0;
      score_p1_q    <= {SCORE_W{1'b0}};
      score_p2_q    <= {SCORE_W{1'b0}};
      hold_active_q <= 1'b0;
      game_over_q   <= 1'b0;
      winner_q      <= WIN_NONE;
    end else begin
      state_q       <= state_d;
      cursor_q      <= cursor_d;
      cards_q       <= cards_d;
      idx_a_q       <= idx_a_d;
      idx_b_q       <= idx_b_d;
      player_q      <= player_d;
      score_p1_q    <= score_p1_d;
      score_p2_q    <= score_p2_d;
      hold_active_q <= hold_active_d;
      game_over_q   <= game_over_d;
      winner_q      <= winner_d;
    end
  end

  // Label under the cursor, blanked while that card is face down.
  always_comb begin
    cur_label_s = {LABEL_W{1'b0}};
    if (cards_q[cursor_q] == HIDDEN) begin
      cur_label_s = {LABEL_W{1'b0}};
    end else begin
      cur_label_s = bus.labels[cursor_q*LABEL_W +: LABEL_W];
    end
  end

  // Flatten the per-card states onto the output bus.
  always_comb begin
    card_state_s = {(2 * N_CARDS){1'b0}};
    for (int i = 0; i < N_CARDS; i++) begin
      card_state_s[2*i +: 2] = cards_q[i];
    end
  end

  assign bus.cursor      = cursor_q;
  assign bus.card_state  = card_state_s;
  assign bus.cur_label   = cur_label_s;
  assign bus.player      = player_q;
  assign bus.score_p1    = score_p1_q;
  assign bus.score_p2    = score_p2_q;
  assign bus.hold_active = hold_active_q;
  assign bus.game_over   = game_over_q;
  assign bus.winner      = winner_q;

endmodule

// File: tb/tb_memory_board_ctrl.sv
// -----------------------------------------------------------------------------
// tb_memory_board_ctrl
// Self-checking bench: a 4-card board (labels 1,2,1,2) and an 8-card board
// (labels 1,1,2,2,3,3,4,4), both with a 3-cycle reveal hold.
// -----------------------------------------------------------------------------
module tb_memory_board_ctrl;

  localparam int HOLD = 3;
  localparam int A_IDLE = 0;
  localparam int A_NEXT = 1;
  localparam int A_PREV = 2;
  localparam int A_BOTH = 3;
  localparam int A_SEL  = 4;
  localparam logic [15:0] LAB4 = 16'h2121;
  localparam logic [31:0] LAB8 = 32'h4433_2211;

  typedef struct packed {
    logic [1:0] cursor;
    logic [7:0] cards;
    logic [3:0] cur_label;
    logic       player;
    logic [5:0] s1;
    logic [5:0] s2;
    logic       hold;
    logic       over;
    logic [1:0] win;
  } obs4_t;

  typedef struct packed {
    logic [15:0] cards;
    logic        player;
    logic [5:0]  s1;
    logic [5:0]  s2;
    logic        hold;
    logic        over;
    logic [1:0]  win;
  } obs8_t;

  typedef struct { int a; obs4_t e; } step4_t;
  typedef struct { int a; bit chk; obs8_t e; } step8_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;
  obs4_t exp_q[$];
  obs8_t exp8_q[$];

  always #5 clk = ~clk;

  memory_board_ctrl_if #(.N_CARDS(4), .LABEL_W(4), .SCORE_W(6)) bus4 ();
  memory_board_ctrl_if #(.N_CARDS(8), .LABEL_W(4), .SCORE_W(6)) bus8 ();

  memory_board_ctrl #(.N_CARDS(4), .LABEL_W(4), .HOLD_CYCLES(HOLD), .SCORE_W(6)) dut4 (
    .clk (clk), .rst (rst), .bus (bus4)
  );
  memory_board_ctrl #(.N_CARDS(8), .LABEL_W(4), .HOLD_CYCLES(HOLD), .SCORE_W(6)) dut8 (
    .clk (clk), .rst (rst), .bus (bus8)
  );

  // Expected 4-card snapshot; cur_label derived from the bench's own label table.
  function automatic obs4_t mk(input logic [1:0] cur, input logic [7:0] cards,
                               input logic pl, input logic [5:0] s1, input logic [5:0] s2,
                               input logic hold, input logic over, input logic [1:0] win);
    obs4_t o;
    logic [15:0] lab;
    lab = LAB4;
    o.cursor    = cur;
    o.cards     = cards;
    o.cur_label = (cards[cur*2 +: 2] == 2'b00) ? 4'd0 : lab[cur*4 +: 4];
    o.player    = pl;
    o.s1        = s1;
    o.s2        = s2;
    o.hold      = hold;
    o.over      = over;
    o.win       = win;
    return o;
  endfunction

  function automatic obs8_t mk8(input logic [15:0] cards, input logic pl,
                                input logic [5:0] s1, input logic [5:0] s2,
                                input logic over, input logic [1:0] win);
    obs8_t o;
    o.cards = cards; o.player = pl; o.s1 = s1; o.s2 = s2;
    o.hold = 1'b0; o.over = over; o.win = win;
    return o;
  endfunction

  function automatic step4_t s4(input int a, input obs4_t e);
    step4_t s;
    s.a = a; s.e = e;
    return s;
  endfunction

  function automatic step8_t s8(input int a, input bit chk, input obs8_t e);
    step8_t s;
    s.a = a; s.chk = chk; s.e = e;
    return s;
  endfunction

  function automatic obs4_t sample4();
    obs4_t o;
    o.cursor = bus4.cursor; o.cards = bus4.card_state; o.cur_label = bus4.cur_label;
    o.player = bus4.player; o.s1 = bus4.score_p1; o.s2 = bus4.score_p2;
    o.hold = bus4.hold_active; o.over = bus4.game_over; o.win = bus4.winner;
    return o;
  endfunction

  function automatic obs8_t sample8();
    obs8_t o;
    o.cards = bus8.card_state; o.player = bus8.player; o.s1 = bus8.score_p1;
    o.s2 = bus8.score_p2; o.hold = bus8.hold_active; o.over = bus8.game_over;
    o.win = bus8.winner;
    return o;
  endfunction

  // One clock cycle of stimulus on board b, sampled 1 time unit after the edge.
  task automatic act(input int b, input int a);
    @(negedge clk);
    if (b == 4) begin
      bus4.move_next = (a == A_NEXT) || (a == A_BOTH);
      bus4.move_prev = (a == A_PREV) || (a == A_BOTH);
      bus4.select    = (a == A_SEL);
    end else begin
      bus8.move_next = (a == A_NEXT) || (a == A_BOTH);
      bus8.move_prev = (a == A_PREV) || (a == A_BOTH);
      bus8.select    = (a == A_SEL);
    end
    @(posedge clk);
    #1;
    bus4.move_next = 1'b0; bus4.move_prev = 1'b0; bus4.select = 1'b0;
    bus8.move_next = 1'b0; bus8.move_prev = 1'b0; bus8.select = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    obs4_t got, e;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back(mk(2'd0, 8'h00, 1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 2'b00));
    got = sample4();
    e = exp_q.pop_front();
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL reset got=%h exp=%h", got, e);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_cursor();
    step4_t st[$];
    obs4_t got, e;
    st.push_back(s4(A_PREV, mk(2'd3, 8'h00, 1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 2'b00)));
    st.push_back(s4(A_NEXT, mk(2'd0, 8'h00, 1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 2'b00)));
    st.push_back(s4(A_BOTH, mk(2'd0, 8'h00, 1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 2'b00)));
    st.push_back(s4(A_NEXT, mk(2'd1, 8'h00, 1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 2'b00)));
    st.push_back(s4(A_BOTH, mk(2'd1, 8'h00, 1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 2'b00)));
    st.push_back(s4(A_PREV, mk(2'd0, 8'h00, 1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 2'b00)));
    for (int i = 0; i < st.size(); i++) begin
      exp_q.push_back(st[i].e);
      act(4, st[i].a);
      got = sample4();
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL cursor step %0d got=%h exp=%h", i, got, e);
      end
    end
  endtask

  task automatic test_match();
    step4_t st[$];
    obs4_t got, e;
    st.push_back(s4(A_SEL,  mk(2'd0, 8'h01, 1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 2'b00)));
    st.push_back(s4(A_NEXT, mk(2'd1, 8'h01, 1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 2'b00)));
    st.push_back(s4(A_NEXT, mk(2'd2, 8'h01, 1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 2'b00)));
    st.push_back(s4(A_SEL,  mk(2'd2, 8'h11, 1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 2'b00)));
    st.push_back(s4(A_IDLE, mk(2'd2, 8'h22, 1'b0, 6'd1, 6'd0, 1'b0, 1'b0, 2'b00)));
    for (int i = 0; i < st.size(); i++) begin
      exp_q.push_back(st[i].e);
      act(4, st[i].a);
      got = sample4();
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL match step %0d got=%h exp=%h", i, got, e);
      end
    end
  endtask

  task automatic test_finish();
    step4_t st[$];
    obs4_t got, e;
    st.push_back(s4(A_PREV, mk(2'd1, 8'h22, 1'b0, 6'd1, 6'd0, 1'b0, 1'b0, 2'b00)));
    st.push_back(s4(A_SEL,  mk(2'd1, 8'h26, 1'b0, 6'd1, 6'd0, 1'b0, 1'b0, 2'b00)));
    st.push_back(s4(A_SEL,  mk(2'd1, 8'h26, 1'b0, 6'd1, 6'd0, 1'b0, 1'b0, 2'b00)));
    st.push_back(s4(A_NEXT, mk(2'd2, 8'h26, 1'b0, 6'd1, 6'd0, 1'b0, 1'b0, 2'b00)));
    st.push_back(s4(A_NEXT, mk(2'd3, 8'h26, 1'b0, 6'd1, 6'd0, 1'b0, 1'b0, 2'b00)));
    st.push_back(s4(A_SEL,  mk(2'd3, 8'h66, 1'b0, 6'd1, 6'd0, 1'b0, 1'b0, 2'b00)));
    st.push_back(s4(A_IDLE, mk(2'd3, 8'hAA, 1'b0, 6'd2, 6'd0, 1'b0, 1'b1, 2'b01)));
    st.push_back(s4(A_NEXT, mk(2'd3, 8'hAA, 1'b0, 6'd2, 6'd0, 1'b0, 1'b1, 2'b01)));
    st.push_back(s4(A_PREV, mk(2'd3, 8'hAA, 1'b0, 6'd2, 6'd0, 1'b0, 1'b1, 2'b01)));
    st.push_back(s4(A_SEL,  mk(2'd3, 8'hAA, 1'b0, 6'd2, 6'd0, 1'b0, 1'b1, 2'b01)));
    for (int i = 0; i < st.size(); i++) begin
      exp_q.push_back(st[i].e);
      act(4, st[i].a);
      got = sample4();
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL finish step %0d got=%h exp=%h", i, got, e);
      end
    end
  endtask

  task automatic test_mismatch_p2_wins();
    step4_t st[$];
    obs4_t got, e;
    pulse_reset();
    st.push_back(s4(A_SEL,  mk(2'd0, 8'h01, 1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 2'b00)));
    st.push_back(s4(A_NEXT, mk(2'd1, 8'h01, 1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 2'b00)));
    st.push_back(s4(A_SEL,  mk(2'd1, 8'h05, 1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 2'b00)));
    st.push_back(s4(A_IDLE, mk(2'd1, 8'h05, 1'b0, 6'd0, 6'd0, 1'b1, 1'b0, 2'b00)));
    st.push_back(s4(A_NEXT, mk(2'd2, 8'h05, 1'b0, 6'd0, 6'd0, 1'b1, 1'b0, 2'b00)));
    st.push_back(s4(A_SEL,  mk(2'd2, 8'h05, 1'b0, 6'd0, 6'd0, 1'b1, 1'b0, 2'b00)));
    st.push_back(s4(A_IDLE, mk(2'd2, 8'h00, 1'b1, 6'd0, 6'd0, 1'b0, 1'b0, 2'b00)));
    st.push_back(s4(A_PREV, mk(2'd1, 8'h00, 1'b1, 6'd0, 6'd0, 1'b0, 1'b0, 2'b00)));
    st.push_back(s4(A_PREV, mk(2'd0, 8'h00, 1'b1, 6'd0, 6'd0, 1'b0, 1'b0, 2'b00)));
    st.push_back(s4(A_SEL,  mk(2'd0, 8'h01, 1'b1, 6'd0, 6'd0, 1'b0, 1'b0, 2'b00)));
    st.push_back(s4(A_NEXT, mk(2'd1, 8'h01, 1'b1, 6'd0, 6'd0, 1'b0, 1'b0, 2'b00)));
    st.push_back(s4(A_NEXT, mk(2'd2, 8'h01, 1'b1, 6'd0, 6'd0, 1'b0, 1'b0, 2'b00)));
    st.push_back(s4(A_SEL,  mk(2'd2, 8'h11, 1'b1, 6'd0, 6'd0, 1'b0, 1'b0, 2'b00)));
    st.push_back(s4(A_IDLE, mk(2'd2, 8'h33, 1'b1, 6'd0, 6'd1, 1'b0, 1'b0, 2'b00)));
    st.push_back(s4(A_PREV, mk(2'd1, 8'h33, 1'b1, 6'd0, 6'd1, 1'b0, 1'b0, 2'b00)));
    st.push_back(s4(A_SEL,  mk(2'd1, 8'h37, 1'b1, 6'd0, 6'd1, 1'b0, 1'b0, 2'b00)));
    st.push_back(s4(A_NEXT, mk(2'd2, 8'h37, 1'b1, 6'd0, 6'd1, 1'b0, 1'b0, 2'b00)));
    st.push_back(s4(A_NEXT, mk(2'd3, 8'h37, 1'b1, 6'd0, 6'd1, 1'b0, 1'b0, 2'b00)));
    st.push_back(s4(A_SEL,  mk(2'd3, 8'h77, 1'b1, 6'd0, 6'd1, 1'b0, 1'b0, 2'b00)));
    st.push_back(s4(A_IDLE, mk(2'd3, 8'hFF, 1'b1, 6'd0, 6'd2, 1'b0, 1'b1, 2'b10)));
    for (int i = 0; i < st.size(); i++) begin
      exp_q.push_back(st[i].e);
      act(4, st[i].a);
      got = sample4();
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL mismatch step %0d got=%h exp=%h", i, got, e);
      end
    end
  endtask

  task automatic test_reset_mid_hold();
    step4_t pre[$];
    step4_t post[$];
    obs4_t got, e;
    pulse_reset();
    pre.push_back(s4(A_SEL,  mk(2'd0, 8'h01, 1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 2'b00)));
    pre.push_back(s4(A_NEXT, mk(2'd1, 8'h01, 1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 2'b00)));
    pre.push_back(s4(A_SEL,  mk(2'd1, 8'h05, 1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 2'b00)));
    pre.push_back(s4(A_IDLE, mk(2'd1, 8'h05, 1'b0, 6'd0, 6'd0, 1'b1, 1'b0, 2'b00)));
    pre.push_back(s4(A_IDLE, mk(2'd1, 8'h05, 1'b0, 6'd0, 6'd0, 1'b1, 1'b0, 2'b00)));
    for (int i = 0; i < pre.size(); i++) begin
      exp_q.push_back(pre[i].e);
      act(4, pre[i].a);
      got = sample4();
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL midhold_pre step %0d got=%h exp=%h", i, got, e);
      end
    end
    // Asynchronous reset: outputs must clear without waiting for a clock edge.
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(mk(2'd0, 8'h00, 1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 2'b00));
    #1;
    got = sample4();
    e = exp_q.pop_front();
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL midhold_async got=%h exp=%h", got, e);
    end
    @(negedge clk);
    rst = 1'b1;
    post.push_back(s4(A_SEL,  mk(2'd0, 8'h01, 1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 2'b00)));
    post.push_back(s4(A_NEXT, mk(2'd1, 8'h01, 1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 2'b00)));
    post.push_back(s4(A_NEXT, mk(2'd2, 8'h01, 1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 2'b00)));
    post.push_back(s4(A_SEL,  mk(2'd2, 8'h11, 1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 2'b00)));
    post.push_back(s4(A_IDLE, mk(2'd2, 8'h22, 1'b0, 6'd1, 6'd0, 1'b0, 1'b0, 2'b00)));
    for (int i = 0; i < post.size(); i++) begin
      exp_q.push_back(post[i].e);
      act(4, post[i].a);
      got = sample4();
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL midhold_post step %0d got=%h exp=%h", i, got, e);
      end
    end
  endtask

  task automatic test_tie();
    step8_t st[$];
    obs8_t got, e;
    obs8_t none;
    none = mk8(16'h0000, 1'b0, 6'd0, 6'd0, 1'b0, 2'b00);
    pulse_reset();
    // P1 takes pairs {0,1} and {2,3}
    st.push_back(s8(A_SEL,  1'b0, none));
    st.push_back(s8(A_NEXT, 1'b0, none));
    st.push_back(s8(A_SEL,  1'b0, none));
    st.push_back(s8(A_IDLE, 1'b1, mk8(16'h000A, 1'b0, 6'd1, 6'd0, 1'b0, 2'b00)));
    st.push_back(s8(A_NEXT, 1'b0, none));
    st.push_back(s8(A_SEL,  1'b0, none));
    st.push_back(s8(A_NEXT, 1'b0, none));
    st.push_back(s8(A_SEL,  1'b0, none));
    st.push_back(s8(A_IDLE, 1'b0, none));
    // P1 misses on cards 4 and 6
    st.push_back(s8(A_NEXT, 1'b0, none));
    st.push_back(s8(A_SEL,  1'b0, none));
    st.push_back(s8(A_NEXT, 1'b0, none));
    st.push_back(s8(A_NEXT, 1'b0, none));
    st.push_back(s8(A_SEL,  1'b0, none));
    st.push_back(s8(A_IDLE, 1'b0, none));
    st.push_back(s8(A_IDLE, 1'b0, none));
    st.push_back(s8(A_IDLE, 1'b0, none));
    st.push_back(s8(A_IDLE, 1'b1, mk8(16'h00AA, 1'b1, 6'd2, 6'd0, 1'b0, 2'b00)));
    // P2 takes pairs {4,5} and {6,7}
    st.push_back(s8(A_PREV, 1'b0, none));
    st.push_back(s8(A_PREV, 1'b0, none));
    st.push_back(s8(A_SEL,  1'b0, none));
    st.push_back(s8(A_NEXT, 1'b0, none));
    st.push_back(s8(A_SEL,  1'b0, none));
    st.push_back(s8(A_IDLE, 1'b0, none));
    st.push_back(s8(A_NEXT, 1'b0, none));
    st.push_back(s8(A_SEL,  1'b0, none));
    st.push_back(s8(A_NEXT, 1'b0, none));
    st.push_back(s8(A_SEL,  1'b0, none));
    st.push_back(s8(A_IDLE, 1'b1, mk8(16'hFFAA, 1'b1, 6'd2, 6'd2, 1'b1, 2'b11)));
    for (int i = 0; i < st.size(); i++) begin
      if (st[i].chk) exp8_q.push_back(st[i].e);
      act(8, st[i].a);
      if (st[i].chk) begin
        got = sample8();
        e = exp8_q.pop_front();
        checks++;
        if (got !== e) begin
          errors++;
          $display("FAIL tie step %0d got=%h exp=%h", i, got, e);
        end
      end
    end
  endtask

  initial begin
    bus4.move_next = 1'b0; bus4.move_prev = 1'b0; bus4.select = 1'b0; bus4.labels = LAB4;
    bus8.move_next = 1'b0; bus8.move_prev = 1'b0; bus8.select = 1'b0; bus8.labels = LAB8;
    test_reset();
    test_cursor();
    test_match();
    test_finish();
    test_mismatch_p2_wins();
    test_reset_mid_hold();
    test_tie();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
